pow2_scale_norm: RTL and testbench
==================================

# pow2_scale_norm

Power-of-two normalizer sitting directly downstream of the max-search stage in the CNN post-processing chain. After the max stage signals completion, the block captures the max value (`scale`) and streams the intermediate memory. It rescales every FP32 element by 2^-(exp(scale)-127) using exponent arithmetic only, with no FP IP, and writes the results to an output memory for the next stage. Normalized magnitudes land in roughly [2^-k, 2), with no multiplier or divider.

## Interface
- `AW`, 12, address width of both memories
- `DW`, 32, data width; only 32 (IEEE-754 single) is supported
- `DATA_SIZE`, 1024, elements per run; must satisfy 2 ≤ `DATA_SIZE` ≤ 2^AW
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle pulse from the upstream done output; starts a run
- `scale_in`  in  DW  max value; valid only in the `start` cycle
- `ready`  out  1  high when a new `start` will be accepted
- `rd_addr`  out  AW  read address into the intermediate memory, which has 1-cycle registered read latency
- `rd_data`  in  DW  read data
- `wr_addr`  out  AW  output memory write address
- `wr_data`  out  DW  normalized element
- `wr_ena`  out  1  write strobe
- `downstream_ready`  in  1  next stage can accept a new buffer
- `done`  out  1  one-cycle pulse after the last write

## Operation
- FSM states: IDLE → RUN → DRAIN → HOLD → IDLE.
- **IDLE**
  - `ready`=1.
  - On `start`=1: latch `scale_in`, clear the counter, go to RUN, drop `ready`.
- **RUN**
  - `rd_addr` = counter, incremented each cycle from 0 to `DATA_SIZE`-1.
  - At `DATA_SIZE`-1, go to DRAIN.
- **DRAIN**
  - Two cycles, flushing the read and compute pipeline.
  - Then pulse `done` and go to HOLD.
- **HOLD**
  - Wait for `downstream_ready`=1, then go to IDLE and raise `ready`.
  - If `downstream_ready` is already 1 in the `done` cycle, go to IDLE on the next edge.
- `start` outside IDLE is ignored: no restart and no re-latch of `scale_in`.
- Shift computation:
  - Let es = exponent field of the latched scale.
  - If 1 ≤ es ≤ 254: shift s = es − 127 (signed, −126..127).
  - Otherwise (zero, denormal, inf or NaN scale, e.g. 0xFF800000): s = 0.
- Per element x with sign sx, exponent ex and mantissa mx:
  - ex = 255 (inf/NaN): pass through unchanged.
  - ex = 0: output {sx, 31'b0} (denormals are flushed).
  - Otherwise ne = ex − s, computed as a 10-bit signed value:
    - ne ≤ 0: output {sx, 31'b0}.
    - ne ≥ 255: output {sx, 8'hFF, 23'b0}.
    - Else: output {sx, ne[7:0], mx}.
- The sign of the scale is ignored; only its exponent field is used.
- `rst` asserted mid-run aborts the run at once. After reset, state is IDLE and the next `start` begins a fresh run; no partial state survives.

## Timing
- Reset values:
  - `ready`=1, `done`=0, `wr_ena`=0.
  - `rd_addr`=0, `wr_addr`=0, `wr_data`=0.
  - Latched scale = 0.
- Cycle numbering, with the `start` cycle as cycle 0:
  - `rd_addr`=k in cycle k+1, for k = 0..N−1.
  - `rd_data` for k arrives in cycle k+2; the result is registered.
  - `wr_ena`=1 with `wr_addr`=k in cycle k+3.
  - `wr_ena` is high for exactly N consecutive cycles, 3..N+2.
  - `done`=1 in cycle N+3 only.
  - Earliest `ready` rise is cycle N+4.
- Latency from element read address to write is 2 cycles. Throughput is 1 element per cycle, with no bubbles.
- `wr_addr` and `wr_data` are don't-care while `wr_ena`=0 but hold their last values.

## Configuration
- Macro `POW2_NORM_UFLOW_CNT_EN`.
- Defined:
  - Adds output port `uflow_cnt` [AW:0].
  - It counts elements flushed to zero by the rule ne ≤ 0 in the current run; denormal inputs are not counted.
  - Cleared on the `start` acceptance and by `rst`.
  - Saturates at 2^(AW+1)−1.
  - Stable from `done` until the next accepted `start`.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

## Test plan
- **Basic scaling.** DATA_SIZE=4, scale 0x41000000 (8.0), memory [0x41800000, 0xC0800000, 0x3F800000, 0x7FC00000] → writes [0x40000000, 0xBF000000, 0x3E000000, 0x7FC00000] at addresses 0..3 in cycles 3..6; `done` in cycle 7.
- **Underflow and overflow.**
  - With scale 0x41000000, x=0x81800000 → 0x80000000 (count 1 when the macro is defined).
  - With scale 0x3A800000 (s=−10), x=0x7F000000 → 0x7F800000.
- **Degenerate scale.** scale 0xFF800000 → every normal element written unchanged, and denormal 0x00000001 → 0x00000000.
- **Handshake.**
  - Hold `downstream_ready`=0 → `ready` stays 0 after `done` until `downstream_ready` rises, then is 1 on the next cycle.
  - A second `start` pulsed in cycle 2 → ignored: no extra writes, and the latched scale is unchanged.
- **Reset mid-run.** Assert `rst` in cycle 5 of a DATA_SIZE=16 run → `wr_ena` 0 and `ready` 1 immediately. A fresh `start` → a full 16-write run with correct addresses 0..15.

Source files
------------

// File: rtl/pow2_scale_norm.sv
// Power-of-two normalizer: rescales each FP32 element by 2^-(exp(scale)-127) via exponent arithmetic.
// Optional underflow counter port enabled by defining POW2_NORM_UFLOW_CNT_EN.
module pow2_scale_norm #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int DATA_SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] scale_in,
  output logic          ready,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_ena,
  input  logic          downstream_ready,
  output logic          done
`ifdef POW2_NORM_UFLOW_CNT_EN
  ,
  output logic [AW:0]   uflow_cnt
`endif
);

  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_RUN     = 2'd1;
  localparam logic [1:0]    S_DRAIN   = 2'd2;
  localparam logic [1:0]    S_HOLD    = 2'd3;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_SIZE - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          drain_q, drain_d;
  logic [7:0]    scale_exp_q, scale_exp_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          rd_vld_q;
  logic [AW-1:0] rd_idx_q;
  logic          wr_ena_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic signed [9:0] shift_s;
  logic signed [9:0] ne_s;
  logic [7:0]        ex_s;
  logic [DW-1:0]     norm_s;
  logic              start_acc_s;

  assign start_acc_s = (state_q == S_IDLE) && start;

  // Control FSM next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    scale_exp_d = scale_exp_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          scale_exp_d = scale_in[30:23];
          cnt_d       = '0;
          ready_d     = 1'b0;
          state_d     = S_RUN;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        drain_d = 1'b0;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          drain_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_HOLD;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (downstream_ready) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b0;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Exponent-only rescale of the element currently on rd_data
  always_comb begin
    ex_s = rd_data[30:23];
    if ((scale_exp_q != 8'd0) && (scale_exp_q != 8'hFF)) begin
      shift_s = $signed({2'b00, scale_exp_q}) - 10'sd127;
    end else begin
      shift_s = 10'sd0;
    end
    ne_s = $signed({2'b00, ex_s}) - shift_s;
    if (ex_s == 8'hFF) begin
      norm_s = rd_data;
    end else if (ex_s == 8'd0) begin
      norm_s = {rd_data[31], 31'd0};
    end else if (ne_s <= 10'sd0) begin
      norm_s = {rd_data[31], 31'd0};
    end else if (ne_s >= 10'sd255) begin
      norm_s = {rd_data[31], 8'hFF, 23'd0};
    end else begin
      norm_s = {rd_data[31], ne_s[7:0], rd_data[22:0]};
    end
  end

  // State, read pipeline and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      scale_exp_q <= 8'd0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      scale_exp_q <= scale_exp_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rd_vld_q    <= (state_q == S_RUN);
      rd_idx_q    <= cnt_q;
      wr_ena_q    <= rd_vld_q;
      if (rd_vld_q) begin
        wr_addr_q <= rd_idx_q;
        wr_data_q <= norm_s;
      end else begin
        wr_addr_q <= wr_addr_q;
        wr_data_q <= wr_data_q;
      end
    end
  end

`ifdef POW2_NORM_UFLOW_CNT_EN
  localparam logic [AW:0] UFLOW_MAX = '1;
  logic [AW:0] uflow_q;
  logic        uflow_hit_s;

  // Denormal inputs are excluded: only true exponent underflow counts
  assign uflow_hit_s = rd_vld_q && (ex_s != 8'd0) && (ex_s != 8'hFF) && (ne_s <= 10'sd0);

  // Saturating per-run underflow counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uflow_q <= '0;
    end else if (start_acc_s) begin
      uflow_q <= '0;
    end else if (uflow_hit_s && (uflow_q != UFLOW_MAX)) begin
      uflow_q <= uflow_q + (AW+1)'(1);
    end else begin
      uflow_q <= uflow_q;
    end
  end

  assign uflow_cnt = uflow_q;
`else
  logic unused_start_acc_s;
  assign unused_start_acc_s = start_acc_s;
`endif

  assign ready   = ready_q;
  assign done    = done_q;
  assign rd_addr = cnt_q;
  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_pow2_scale_norm.sv
// Scoreboard bench for pow2_scale_norm: randomized runs checked against an arithmetic reference model.
module tb_pow2_scale_norm;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] scale_in;
  logic          ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ena;
  logic          downstream_ready;
  logic          done;
`ifdef POW2_NORM_UFLOW_CNT_EN
  logic [AW:0]   uflow_cnt;
`endif

  pow2_scale_norm #(.AW(AW), .DW(DW), .DATA_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start), .scale_in(scale_in), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ena(wr_ena), .downstream_ready(downstream_ready), .done(done)
`ifdef POW2_NORM_UFLOW_CNT_EN
    , .uflow_cnt(uflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Intermediate memory with one-cycle registered read
  logic [31:0] mem [N];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int shift_of(input logic [31:0] sc);
    int es;
    es = int'(sc[30:23]);
    return (es >= 1 && es <= 254) ? es - 127 : 0;
  endfunction

  function automatic logic [31:0] ref_norm(input logic [31:0] x, input logic [31:0] sc);
    int ex, ne;
    logic [7:0] e8;
    ex = int'(x[30:23]);
    if (ex == 255) return x;
    if (ex == 0) return {x[31], 31'd0};
    ne = ex - shift_of(sc);
    if (ne <= 0) return {x[31], 31'd0};
    if (ne >= 255) return {x[31], 8'hFF, 23'd0};
    e8 = 8'(ne);
    return {x[31], e8, x[22:0]};
  endfunction

  function automatic int ref_uflow(input logic [31:0] sc);
    int cnt, ex;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      ex = int'(mem[k][30:23]);
      if (ex != 0 && ex != 255 && (ex - shift_of(sc)) <= 0) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'd0;
      1: r[30:23] = 8'hFF;
      2: r[30:23] = 8'($urandom_range(1, 20));
      3: r[30:23] = 8'($urandom_range(235, 254));
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: every write is popped from the scoreboard and compared
  always @(negedge clk) begin
    wr_t e;
    if (!rst && wr_ena) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d with empty queue, expected no write", wr_addr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic run(input logic [31:0] sc, input int dr_delay, input bit second_start, input int rst_cycle);
    int t;
    int exp_uf;
    @(posedge clk); #1;
    t = 0;
    while (!ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_idle", 32'(ready), 32'd1);
    for (int k = 0; k < N; k++) sb.push_back('{addr: AW'(k), data: ref_norm(mem[k], sc)});
    exp_uf = ref_uflow(sc);
    downstream_ready = (dr_delay == 0);
    start    = 1'b1;
    scale_in = sc;
    for (int cyc = 1; cyc <= N + 3; cyc++) begin
      @(posedge clk); #1;
      start    = second_start && (cyc == 2);
      scale_in = start ? (sc ^ 32'h0F800000) : $urandom();
      if (cyc == rst_cycle) begin
        rst = 1'b1;
        #1;
        chk("rst_wr_ena", 32'(wr_ena), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        sb.delete();
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      if (cyc <= N) chk("rd_addr", 32'(rd_addr), 32'(cyc - 1));
      chk("wr_ena_window", 32'(wr_ena), 32'(cyc >= 3 && cyc <= N + 2));
      chk("done_timing", 32'(done), 32'(cyc == N + 3));
      chk("ready_busy", 32'(ready), 32'd0);
    end
`ifdef POW2_NORM_UFLOW_CNT_EN
    chk("uflow_cnt", 32'(uflow_cnt), 32'(exp_uf));
`endif
    if (dr_delay > 0) begin
      for (int d = 0; d < dr_delay; d++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_hold", 32'(ready), 32'd0);
        chk("done_once", 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      downstream_ready = 1'b1;
      @(negedge clk);
      chk("ready_hold_last", 32'(ready), 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_rise", 32'(ready), 32'd1);
    chk("done_low", 32'(done), 32'd0);
`ifdef POW2_NORM_UFLOW_CNT_EN
    chk("uflow_stable", 32'(uflow_cnt), 32'(exp_uf));
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] sc;
    rst = 1'b1;
    start = 1'b0;
    scale_in = '0;
    downstream_ready = 1'b1;
    for (int k = 0; k < N; k++) mem[k] = rand_fp();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_wr_ena", 32'(wr_ena), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
`ifdef POW2_NORM_UFLOW_CNT_EN
    chk("reset_uflow", 32'(uflow_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Basic scaling plus underflow element
    mem[0] = 32'h41800000; mem[1] = 32'hC0800000; mem[2] = 32'h3F800000; mem[3] = 32'h7FC00000;
    mem[4] = 32'h81800000;
    run(32'h41000000, 0, 1'b0, 0);

    // Overflow with negative shift
    for (int k = 0; k < N; k++) mem[k] = rand_fp();
    mem[0] = 32'h7F000000;
    run(32'h3A800000, 0, 1'b0, 0);

    // Degenerate scale and denormal flush
    for (int k = 0; k < N; k++) mem[k] = rand_fp();
    mem[0] = 32'h00000001;
    run(32'hFF800000, 0, 1'b0, 0);

    // Handshake stall and ignored second start
    for (int k = 0; k < N; k++) mem[k] = rand_fp();
    run(32'h40000000, 3, 1'b1, 0);

    // Reset mid-run then a full fresh run
    for (int k = 0; k < N; k++) mem[k] = rand_fp();
    run(32'h43000000, 0, 1'b0, 5);
    run(32'h43000000, 0, 1'b0, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) mem[k] = rand_fp();
      sc = rand_fp();
      run(sc, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
